fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction SRAM-like
//  req/addr_ok/data_ok handshake, and holds the IF/ID pipeline register. Consumes
//  stall_pc, stall_if_id and flush_if_id from the hazard unit, plus the branch/jump
//  redirect from ID. Keeps at most one outstanding fetch and has a 1-entry hold buffer.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000  PC value after reset
//  ADDR_W     32             instruction address width
//  DATA_W     32             instruction word width
// PORTS
//  clk            in   1       pipeline clock
//  resetn         in   1       async reset, active low
//  stall_pc       in   1       hold PC; issue no new request
//  stall_if_id    in   1       hold IF/ID register contents
//  flush_if_id    in   1       invalidate IF/ID and hold buffer
//  redirect_valid in   1       taken branch/jump from ID
//  redirect_pc    in   ADDR_W  redirect target
//  inst_req       out  1       fetch request
//  inst_addr      out  ADDR_W  fetch address (word aligned)
//  inst_addr_ok   in   1       request accepted this cycle
//  inst_data_ok   in   1       instruction returned this cycle
//  inst_rdata     in   DATA_W  returned instruction
//  if_id_valid    out  1       IF/ID holds a live instruction
//  if_id_pc       out  ADDR_W  PC of IF/ID instruction
//  if_id_inst     out  DATA_W  IF/ID instruction (0 = NOP when invalid)
// BEHAVIOUR
//  Reset (async, resetn=0): pc=RESET_PC, state=IDLE, inst_req=0, if_id_valid=0,
//   if_id_pc=0, if_id_inst=0, hold buffer empty, discard flag=0.
//  FSM: IDLE -> REQ when !stall_pc and hold buffer empty.
//   REQ: inst_req=1, inst_addr=pc; inst_addr_ok -> WAIT. inst_req stays high, addr stable, until accepted.
//   WAIT: inst_req=0; on inst_data_ok -> IDLE (or REQ same cycle if issue conditions hold).
//  Issue conditions evaluated combinationally; a request may be accepted every other cycle minimum.
//  Data return (inst_data_ok, discard=0): if !stall_if_id and buffer empty -> write IF/ID
//   next edge (valid=1); if stall_if_id -> write hold buffer. Never both.
//  IF/ID refill: when !stall_if_id and buffer full, buffer moves into IF/ID, buffer empties.
//  !stall_if_id with nothing to load -> if_id_valid=0 (bubble).
//  PC update on inst_addr_ok: pc <= pc+4 (wraps mod 2^ADDR_W); redirect overrides.
//  redirect_valid: pc <= redirect_pc, regardless of stall_pc. In REQ not yet accepted:
//   inst_addr switches to redirect_pc next cycle. In WAIT: discard=1; returned data dropped.
//  redirect_valid and inst_addr_ok same cycle: accepted fetch marked discard, pc <= redirect_pc.
//  flush_if_id: if_id_valid=0 and buffer cleared next edge; priority over stall_if_id and
//   over a same-cycle data return (that data is dropped).
//  stall_pc in REQ before acceptance: inst_req held (request not withdrawn).
//  redirect_pc with addr[1:0]!=0: forced word aligned (low bits zeroed); no exception here.
//  Latency: inst_addr_ok to if_id_valid = SRAM latency + 1 edge.
// STRUCTURE
//  Shared package/header mips_defs: RESET_PC, NOP_INST=32'h0, FSM state encodings
//  (IDLE/REQ/WAIT). One natural sub-module: if_hold_buf (1-entry pc+inst buffer,
//  write/read/clear). PC register and FSM stay in fetch_unit.
// TESTING
//  Reset release, addr_ok/data_ok every cycle -> inst_addr 0xBFC00000,0xBFC00004,...; IF/ID
//   valid one edge after each data_ok with matching pc.
//  stall_if_id=1 when data_ok returns inst 0x24020001 -> IF/ID unchanged, buffer holds it, no
//   new req; stall drops -> IF/ID shows 0x24020001, req resumes.
//  redirect_valid=1, redirect_pc=0xBFC00100 while in WAIT -> returned word dropped, next
//   inst_addr=0xBFC00100.
//  flush_if_id with buffer full and data_ok same cycle -> if_id_valid=0, buffer empty, data lost.
//  addr_ok held low 5 cycles -> inst_req and inst_addr stable throughout; pc unchanged.
//  resetn asserted in WAIT -> all outputs at reset values immediately; late data_ok ignored.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// ============================================================================
// mips_defs_pkg : shared constants for the MIPS pipeline front end
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

package mips_defs_pkg;

  localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;
  localparam logic [31:0] c_nop_inst = 32'h0000_0000;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;

endpackage

`default_nettype wire

// File: rtl/if_hold_buf.sv
// ============================================================================
// if_hold_buf : one-entry pc+instruction buffer for returns that arrive while
//               IF/ID is stalled
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module if_hold_buf
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [DATA_W-1:0] wr_inst,
  input  logic              rd_en,
  output logic              full,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst
);

  logic              r_full;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;

  // clear beats write beats read; a write during a read keeps the entry full
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_full <= 1'b0;
      r_pc   <= '0;
      r_inst <= DATA_W'(c_nop_inst);
    end else if (clr) begin
      r_full <= 1'b0;
    end else if (wr_en) begin
      r_full <= 1'b1;
      r_pc   <= wr_pc;
      r_inst <= wr_inst;
    end else if (rd_en) begin
      r_full <= 1'b0;
    end
  end

  assign full = r_full;
  assign pc   = r_pc;
  assign inst = r_inst;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : MIPS IF stage - PC, single-outstanding instruction fetch and
//              the IF/ID pipeline register
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import mips_defs_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = c_reset_pc
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_pc,
  input  logic              stall_if_id,
  input  logic              flush_if_id,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_inst
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_discard;

  logic              r_if_id_valid;
  logic [ADDR_W-1:0] r_if_id_pc;
  logic [DATA_W-1:0] r_if_id_inst;

  logic              w_addr_fire;
  logic              w_data_ret;
  logic              w_data_fire;
  logic              w_issue;
  logic [ADDR_W-1:0] w_redirect_pc;

  logic              w_buf_full;
  logic              w_buf_wr;
  logic              w_buf_rd;
  logic              w_buf_full_nxt;
  logic [ADDR_W-1:0] w_buf_pc;
  logic [DATA_W-1:0] w_buf_inst;

  assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
  assign w_addr_fire   = (r_state == c_st_req)  && inst_addr_ok;
  assign w_data_ret    = (r_state == c_st_wait) && inst_data_ok;

  // a redirect seen while waiting makes the in-flight word wrong-path
  assign w_data_fire = w_data_ret && !r_discard && !redirect_valid && !flush_if_id;

  assign w_buf_wr = w_data_fire && (stall_if_id || w_buf_full);
  assign w_buf_rd = !flush_if_id && !stall_if_id && w_buf_full;

  always_comb begin
    w_buf_full_nxt = w_buf_full;
    if (flush_if_id)
      w_buf_full_nxt = 1'b0;
    else if (w_buf_wr)
      w_buf_full_nxt = 1'b1;
    else if (w_buf_rd)
      w_buf_full_nxt = 1'b0;
  end

  // never issue if the buffer will be occupied, so a return always has a home
  assign w_issue = !stall_pc && !w_buf_full_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_issue) w_state_nxt = c_st_req;
      c_st_req:  if (inst_addr_ok) w_state_nxt = c_st_wait;
      c_st_wait: if (inst_data_ok) w_state_nxt = w_issue ? c_st_req : c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= c_st_idle;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid)
        r_pc <= w_redirect_pc;
      else if (w_addr_fire)
        r_pc <= r_pc + ADDR_W'(4);
      if (w_addr_fire)
        r_req_pc <= r_pc;
      if (w_data_ret)
        r_discard <= 1'b0;
      else if (redirect_valid && (w_addr_fire || (r_state == c_st_wait)))
        r_discard <= 1'b1;
    end
  end

  if_hold_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (flush_if_id),
    .wr_en   (w_buf_wr),
    .wr_pc   (r_req_pc),
    .wr_inst (inst_rdata),
    .rd_en   (w_buf_rd),
    .full    (w_buf_full),
    .pc      (w_buf_pc),
    .inst    (w_buf_inst)
  );

  // buffered word is older than any same-cycle return, so it loads first
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_inst  <= DATA_W'(c_nop_inst);
    end else if (flush_if_id) begin
      r_if_id_valid <= 1'b0;
      r_if_id_inst  <= DATA_W'(c_nop_inst);
    end else if (!stall_if_id) begin
      if (w_buf_full) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= w_buf_pc;
        r_if_id_inst  <= w_buf_inst;
      end else if (w_data_fire) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_req_pc;
        r_if_id_inst  <= inst_rdata;
      end else begin
        r_if_id_valid <= 1'b0;
        r_if_id_inst  <= DATA_W'(c_nop_inst);
      end
    end
  end

  assign inst_req    = (r_state == c_st_req);
  assign inst_addr   = r_pc;
  assign if_id_valid = r_if_id_valid;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_inst  = r_if_id_inst;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_pc, stall_if_id, flush_if_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_inst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .flush_if_id    (flush_if_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one fetch with addr_ok immediately and data_ok on the following cycle
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    check("req_hi", 32'(inst_req), 32'd1);
    check("req_addr", inst_addr, addr);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    check("req_lo_wait", 32'(inst_req), 32'd0);
    inst_data_ok = 1'b1;
    inst_rdata   = data;
    tick();
    inst_data_ok = 1'b0;
    check("ifid_valid", 32'(if_id_valid), 32'd1);
    check("ifid_pc", if_id_pc, addr);
    check("ifid_inst", if_id_inst, data);
  endtask

  initial begin
    resetn         = 1'b0;
    stall_pc       = 1'b0;
    stall_if_id    = 1'b0;
    flush_if_id    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'h0;

    #12;
    check("rst_req", 32'(inst_req), 32'd0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_inst", if_id_inst, 32'h0);
    check("rst_addr", inst_addr, 32'hBFC0_0000);

    tick();
    resetn = 1'b1;
    check("idle_req", 32'(inst_req), 32'd0);
    tick();

    // back-to-back fetches
    fetch_one(32'hBFC0_0000, 32'h1111_1111);
    fetch_one(32'hBFC0_0004, 32'h2222_2222);
    fetch_one(32'hBFC0_0008, 32'h3333_3333);

    // return while IF/ID stalled goes to the hold buffer
    stall_if_id  = 1'b1;
    check("stl_addr", inst_addr, 32'hBFC0_000C);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h2402_0001;
    tick();
    inst_data_ok = 1'b0;
    check("stl_valid", 32'(if_id_valid), 32'd1);
    check("stl_pc", if_id_pc, 32'hBFC0_0008);
    check("stl_inst", if_id_inst, 32'h3333_3333);
    check("stl_noreq", 32'(inst_req), 32'd0);
    tick();
    check("stl_noreq2", 32'(inst_req), 32'd0);
    check("stl_inst2", if_id_inst, 32'h3333_3333);
    stall_if_id = 1'b0;
    tick();
    check("refill_valid", 32'(if_id_valid), 32'd1);
    check("refill_pc", if_id_pc, 32'hBFC0_000C);
    check("refill_inst", if_id_inst, 32'h2402_0001);
    check("refill_req", 32'(inst_req), 32'd1);
    check("refill_addr", inst_addr, 32'hBFC0_0010);

    // redirect while waiting drops the returning word
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hBFC0_0100;
    tick();
    redirect_valid = 1'b0;
    check("rdw_req", 32'(inst_req), 32'd0);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 1'b0;
    check("rdw_valid", 32'(if_id_valid), 32'd0);
    check("rdw_inst", if_id_inst, 32'h0);
    check("rdw_req2", 32'(inst_req), 32'd1);
    check("rdw_addr", inst_addr, 32'hBFC0_0100);

    // addr_ok withheld, also under stall_pc: request must not move
    stall_pc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_req", 32'(inst_req), 32'd1);
      check("hold_addr", inst_addr, 32'hBFC0_0100);
    end
    stall_pc = 1'b0;
    fetch_one(32'hBFC0_0100, 32'h5555_5555);

    // flush beats a stalled same-cycle return
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h6666_6666;
    stall_if_id  = 1'b1;
    flush_if_id  = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    flush_if_id  = 1'b0;
    stall_if_id  = 1'b0;
    check("fla_valid", 32'(if_id_valid), 32'd0);
    check("fla_inst", if_id_inst, 32'h0);
    check("fla_req", 32'(inst_req), 32'd1);
    check("fla_addr", inst_addr, 32'hBFC0_0108);
    tick();
    check("fla_bubble", 32'(if_id_valid), 32'd0);

    // flush with buffer full empties the buffer
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h7777_7777;
    stall_if_id  = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    check("flb_noreq", 32'(inst_req), 32'd0);
    flush_if_id = 1'b1;
    tick();
    flush_if_id = 1'b0;
    stall_if_id = 1'b0;
    check("flb_valid", 32'(if_id_valid), 32'd0);
    check("flb_req", 32'(inst_req), 32'd1);
    check("flb_addr", inst_addr, 32'hBFC0_010C);
    tick();
    check("flb_lost_valid", 32'(if_id_valid), 32'd0);
    check("flb_lost_inst", if_id_inst, 32'h0);

    // unaligned redirect before acceptance retargets the pending request
    redirect_valid = 1'b1;
    redirect_pc    = 32'hBFC0_0203;
    tick();
    redirect_valid = 1'b0;
    check("rdr_req", 32'(inst_req), 32'd1);
    check("rdr_addr", inst_addr, 32'hBFC0_0200);

    // redirect in the same cycle as acceptance discards that fetch
    inst_addr_ok   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hBFC0_0300;
    tick();
    inst_addr_ok   = 1'b0;
    redirect_valid = 1'b0;
    inst_data_ok   = 1'b1;
    inst_rdata     = 32'h8888_8888;
    tick();
    inst_data_ok = 1'b0;
    check("rda_valid", 32'(if_id_valid), 32'd0);
    check("rda_addr", inst_addr, 32'hBFC0_0300);

    // pc wraps past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h1234_5678);
    check("wrap_addr", inst_addr, 32'h0000_0000);

    // reset asserted mid-fetch, then a late data_ok
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_req", 32'(inst_req), 32'd0);
    check("arst_valid", 32'(if_id_valid), 32'd0);
    check("arst_pc", if_id_pc, 32'h0);
    check("arst_inst", if_id_inst, 32'h0);
    check("arst_addr", inst_addr, 32'hBFC0_0000);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hAAAA_AAAA;
    tick();
    resetn = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    check("late_valid", 32'(if_id_valid), 32'd0);
    check("late_inst", if_id_inst, 32'h0);
    check("late_req", 32'(inst_req), 32'd1);
    check("late_addr", inst_addr, 32'hBFC0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
